// File: rtl/brick_field.sv
`default_nettype none
// brick_field: 4x10 brick map fed by ball break events, with score, bricks-left and timed refill.
// Optional macro BRICK_HP_EN makes row-0 bricks two-hit (per-brick 2-bit hit points).
module brick_field #(
  parameter int ROWS            = 4,
  parameter int COLS            = 10,
  parameter int SCORE_PER_BRICK = 10,
  parameter int REFILL_DELAY    = 30
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  key,
  input  logic        Brick_Broke,
  input  int          BreakX,
  input  int          BreakY,
  output int          Bricks [ROWS][COLS],
  output logic [5:0]  bricks_left,
  output logic [15:0] score,
  output logic        field_clear
);

  localparam logic [7:0]  RESTART_KEY = 8'h15;
  localparam logic [5:0]  FULL_COUNT  = 6'(ROWS * COLS);
  localparam logic [5:0]  ROW_COUNT   = 6'(COLS);
  localparam int          DW          = (REFILL_DELAY > 1) ? $clog2(REFILL_DELAY) : 1;
  localparam int          PW          = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [DW-1:0] DELAY_LAST = DW'(REFILL_DELAY - 1);
  localparam logic [PW-1:0] TOP_ROW    = PW'(ROWS - 1);
  localparam logic [16:0] ADD_ONE     = 17'(SCORE_PER_BRICK);
  localparam logic [16:0] ADD_TWO     = 17'(2 * SCORE_PER_BRICK);

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    CLEAR_WAIT = 2'd1,
    REFILL     = 2'd2
  } state_t;

  typedef logic [ROWS-1:0][COLS-1:0] map_t;

  state_t          state_q, state_d;
  map_t            map_q, map_d;
  logic [5:0]      left_q, left_d;
  logic [15:0]     score_q, score_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  map_t            hit_mask;
  logic            hit;
  logic            dent;
  logic [16:0]     add;
  logic [16:0]     score_sum;
  logic [15:0]     score_sat;

`ifdef BRICK_HP_EN
  typedef logic [ROWS-1:0][COLS-1:0][1:0] hp_t;

  function automatic hp_t hp_full();
    hp_t v;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        v[r][c] = (r == 0) ? 2'd2 : 2'd1;
      end
    end
    return v;
  endfunction

  localparam hp_t HP_FULL = hp_full();

  hp_t        hp_q, hp_d;
  logic [1:0] hit_hp;
`endif

  // Decode the break coordinate; out-of-range indices match no brick, so hit stays 0.
  always_comb begin
    hit_mask = '0;
    hit      = 1'b0;
`ifdef BRICK_HP_EN
    hit_hp   = 2'd0;
`endif
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (BreakX == r && BreakY == c) begin
          hit_mask[r][c] = 1'b1;
          hit            = map_q[r][c];
`ifdef BRICK_HP_EN
          hit_hp         = hp_q[r][c];
`endif
        end
      end
    end
  end

`ifdef BRICK_HP_EN
  assign dent = (hit_hp == 2'd2);
  assign add  = (BreakX == 0) ? ADD_TWO : ADD_ONE;
`else
  assign dent = 1'b0;
  assign add  = ADD_ONE;
`endif

  assign score_sum = {1'b0, score_q} + add;
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    left_d  = left_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
`ifdef BRICK_HP_EN
    hp_d    = hp_q;
`endif
    if (key == RESTART_KEY) begin
      state_d = PLAY;
      map_d   = '1;
      left_d  = FULL_COUNT;
      score_d = '0;
      cnt_d   = '0;
      ptr_d   = '0;
`ifdef BRICK_HP_EN
      hp_d    = HP_FULL;
`endif
    end else begin
      case (state_q)
        PLAY: begin
          if (Brick_Broke && hit) begin
            if (dent) begin
`ifdef BRICK_HP_EN
              for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                  if (hit_mask[r][c]) hp_d[r][c] = 2'd1;
                end
              end
`endif
            end else begin
              map_d   = map_q & ~hit_mask;
              left_d  = left_q - 6'd1;
              score_d = score_sat;
              if (left_q == 6'd1) begin
                state_d = CLEAR_WAIT;
                cnt_d   = '0;
              end
            end
          end
        end
        CLEAR_WAIT: begin
          if (cnt_q == DELAY_LAST) begin
            state_d = REFILL;
            ptr_d   = TOP_ROW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REFILL: begin
          map_d[ptr_q] = '1;
          left_d       = left_q + ROW_COUNT;
`ifdef BRICK_HP_EN
          hp_d[ptr_q]  = HP_FULL[ptr_q];
`endif
          if (ptr_q == '0) begin
            state_d = PLAY;
          end else begin
            ptr_d = ptr_q - 1'b1;
          end
        end
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= PLAY;
      map_q   <= '1;
      left_q  <= FULL_COUNT;
      score_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
`ifdef BRICK_HP_EN
      hp_q    <= HP_FULL;
`endif
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      left_q  <= left_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
`ifdef BRICK_HP_EN
      hp_q    <= hp_d;
`endif
    end
  end

  generate
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < COLS; gc++) begin : g_col
        assign Bricks[gr][gc] = int'(map_q[gr][gc]);
      end
    end
  endgenerate

  assign bricks_left = left_q;
  assign score       = score_q;
  assign field_clear = (state_q != PLAY);

endmodule
`default_nettype wire

// File: tb/tb_brick_field.sv
`default_nettype none
// tb_brick_field: directed scenarios plus randomized play against a frame-level reference model.
module tb_brick_field;

  localparam int ROWS  = 4;
  localparam int COLS  = 10;
  localparam int DELAY = 30;
  localparam int PTS   = 10;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  key;
  logic        Brick_Broke;
  int          BreakX;
  int          BreakY;
  int          Bricks [ROWS][COLS];
  logic [5:0]  bricks_left;
  logic [15:0] score;
  logic        field_clear;

  int total = 0;
  int bad   = 0;

  // reference model
  int m_map [ROWS][COLS];
  int m_hp  [ROWS][COLS];
  int m_score;
  bit m_clearing;
  int m_t;

  always #5 frame_clk = ~frame_clk;

  brick_field dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .key         (key),
    .Brick_Broke (Brick_Broke),
    .BreakX      (BreakX),
    .BreakY      (BreakY),
    .Bricks      (Bricks),
    .bricks_left (bricks_left),
    .score       (score),
    .field_clear (field_clear)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        n += m_map[r][c];
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_map[r][c] = 1;
`ifdef BRICK_HP_EN
        m_hp[r][c] = (r == 0) ? 2 : 1;
`else
        m_hp[r][c] = 1;
`endif
      end
    m_score    = 0;
    m_clearing = 0;
    m_t        = 0;
  endtask

  // One frame of the game rules, using the inputs presented at this edge.
  task automatic model_edge();
    int pts;
    if (key == 8'h15) begin
      model_reset();
      return;
    end
    if (m_clearing) begin
      m_t++;
      if (m_t > DELAY) begin
        int row = DELAY + ROWS - m_t;
        for (int c = 0; c < COLS; c++) begin
          m_map[row][c] = 1;
`ifdef BRICK_HP_EN
          m_hp[row][c] = (row == 0) ? 2 : 1;
`else
          m_hp[row][c] = 1;
`endif
        end
      end
      if (m_t == DELAY + ROWS) m_clearing = 0;
    end else if (Brick_Broke && BreakX >= 0 && BreakX < ROWS && BreakY >= 0 && BreakY < COLS
                 && m_map[BreakX][BreakY] == 1) begin
      if (m_hp[BreakX][BreakY] == 2) begin
        m_hp[BreakX][BreakY] = 1;
      end else begin
        m_map[BreakX][BreakY] = 0;
`ifdef BRICK_HP_EN
        pts = (BreakX == 0) ? 2 * PTS : PTS;
`else
        pts = PTS;
`endif
        m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
        if (m_count() == 0) begin
          m_clearing = 1;
          m_t        = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [ROWS*COLS-1:0] got_v, exp_v;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        got_v[r*COLS+c] = (Bricks[r][c] == 1);
        exp_v[r*COLS+c] = (m_map[r][c] == 1);
      end
    check({tag, "_map"},   64'(got_v), 64'(exp_v));
    check({tag, "_left"},  64'(bricks_left), 64'(m_count()));
    check({tag, "_score"}, 64'(score), 64'(m_score));
    check({tag, "_clear"}, 64'(field_clear), 64'(m_clearing));
  endtask

  // Called at a negedge: drive, clock once, update model, then check at the next negedge.
  task automatic step(input bit brk, input int x, input int y, input logic [7:0] k, input string tag);
    Brick_Broke = brk;
    BreakX      = x;
    BreakY      = y;
    key         = k;
    @(posedge frame_clk);
    model_edge();
    @(negedge frame_clk);
    check_all(tag);
  endtask

  task automatic clear_field(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int n = 0; n < 3 && m_map[r][c] == 1 && !m_clearing; n++)
          step(1'b1, r, c, 8'h00, tag);
  endtask

  initial begin
    Reset       = 1'b1;
    key         = 8'h00;
    Brick_Broke = 1'b0;
    BreakX      = 0;
    BreakY      = 0;
    model_reset();
    @(negedge frame_clk);
    check_all("reset");
    check("reset_left_const", 64'(bricks_left), 64'd40);
    Reset = 1'b0;

    step(1'b1, 2, 5, 8'h00, "t1");
    check("t1_brick", 64'(Bricks[2][5]), 64'd0);
    check("t1_left",  64'(bricks_left), 64'd39);
    check("t1_score", 64'(score), 64'd10);

    for (int i = 0; i < 3; i++) step(1'b1, 2, 5, 8'h00, "t2");
    check("t2_left",  64'(bricks_left), 64'd39);
    check("t2_score", 64'(score), 64'd10);

    step(1'b0, 0, 0, 8'h15, "t3_rst");
    step(1'b1, 4, 3, 8'h00, "t3_a");
    step(1'b1, 0, 10, 8'h00, "t3_b");
    step(1'b1, -1, 2, 8'h00, "t3_c");
    check("t3_left",  64'(bricks_left), 64'd40);
    check("t3_score", 64'(score), 64'd0);

    step(1'b0, 0, 0, 8'h15, "t4_rst");
    clear_field("t4_brk");
    check("t4_fc_on", 64'(field_clear), 64'd1);
    check("t4_empty", 64'(bricks_left), 64'd0);
    for (int i = 0; i < DELAY + ROWS; i++) step(1'b1, 1, 1, 8'h00, "t4_wait");
    check("t4_left",  64'(bricks_left), 64'd40);
    check("t4_fc_off", 64'(field_clear), 64'd0);
`ifdef BRICK_HP_EN
    check("t4_score", 64'(score), 64'd500);
`else
    check("t4_score", 64'(score), 64'd400);
`endif

    step(1'b1, 3, 3, 8'h00, "t5_pre");
    step(1'b1, 1, 1, 8'h15, "t5");
    check("t5_brick", 64'(Bricks[1][1]), 64'd1);
    check("t5_left",  64'(bricks_left), 64'd40);
    check("t5_score", 64'(score), 64'd0);

    // Async reset while the wall is being refilled.
    clear_field("rr_brk");
    for (int i = 0; i < DELAY + 1; i++) step(1'b0, 0, 0, 8'h00, "rr_wait");
    check("rr_mid_left", 64'(bricks_left), 64'd10);
    check("rr_mid_fc",   64'(field_clear), 64'd1);
    #1 Reset = 1'b1;
    #1;
    model_reset();
    check_all("rr_async");
    check("rr_fc", 64'(field_clear), 64'd0);
    @(negedge frame_clk);
    check_all("rr_hold");
    Reset = 1'b0;

`ifdef BRICK_HP_EN
    step(1'b1, 0, 0, 8'h00, "t6_a");
    check("t6_a_brick", 64'(Bricks[0][0]), 64'd1);
    check("t6_a_score", 64'(score), 64'd0);
    step(1'b1, 0, 0, 8'h00, "t6_b");
    check("t6_b_brick", 64'(Bricks[0][0]), 64'd0);
    check("t6_b_score", 64'(score), 64'd20);
`endif

    for (int i = 0; i < 3000; i++) begin
      int kind = $urandom_range(0, 399);
      logic [7:0] k = 8'h00;
      int x, y;
      if (kind == 0) k = 8'h15;
      else if (kind < 8) k = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        int start = $urandom_range(0, ROWS * COLS - 1);
        x = start / COLS;
        y = start % COLS;
        for (int j = 0; j < ROWS * COLS; j++) begin
          int idx = (start + j) % (ROWS * COLS);
          if (m_map[idx / COLS][idx % COLS] == 1) begin
            x = idx / COLS;
            y = idx % COLS;
            break;
          end
        end
      end else begin
        x = $urandom_range(0, ROWS + 1) - 1;
        y = $urandom_range(0, COLS + 1) - 1;
      end
      step($urandom_range(0, 9) < 7, x, y, k, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
